// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture RAM dump reader.
//   state_e        : dump FSM state encoding
//   DefaultEntries : default number of valid RAM locations
//   DefaultLog2    : default RAM address width
//   wrap_inc()     : circular increment that wraps at an arbitrary entry count
package capture_pkg;

  localparam int unsigned DefaultEntries = 384;
  localparam int unsigned DefaultLog2    = 9;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StSend,
    StWaitTx,
    StDone
  } state_e;

  // next(a): entries need not be a power of two, so wrap explicitly.
  function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned entries);
    return (a == entries - 1) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/capture_dump_reader_if.sv
// Bundle of the dump reader's control, RAM read and UART transmit signals.
//   master : the dump reader (drives raddr, tx_data, trmt, busy, done)
//   slave  : its environment (capture FSM, RAM queue, UART)
interface capture_dump_reader_if #(
  parameter int unsigned LOG2 = capture_pkg::DefaultLog2
);
  logic            start;
  logic [LOG2-1:0] start_addr;
  logic [LOG2:0]   dump_len;
  logic [LOG2-1:0] raddr;
  logic [7:0]      rdata;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            tx_done;
  logic            busy;
  logic            done;

  modport master (
    input  start, start_addr, dump_len, rdata, tx_done,
    output raddr, tx_data, trmt, busy, done
  );

  modport slave (
    output start, start_addr, dump_len, rdata, tx_done,
    input  raddr, tx_data, trmt, busy, done
  );
endinterface

// File: rtl/circ_addr_ctr.sv
// Loadable circular address counter wrapping at ENTRIES.
//   clk, rst_n : clock, async active-low reset (addr resets to 0)
//   load       : load load_val (reduced by ENTRIES once if out of range)
//   load_val   : address to load
//   inc        : advance to next(addr); load has priority
//   addr       : registered current address, always < ENTRIES
module circ_addr_ctr
  import capture_pkg::*;
#(
  parameter int unsigned ENTRIES = DefaultEntries,
  parameter int unsigned LOG2    = DefaultLog2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [LOG2-1:0] load_val,
  input  logic            inc,
  output logic [LOG2-1:0] addr
);

  localparam logic [LOG2-1:0] EntriesA = LOG2'(ENTRIES);

  logic [LOG2-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      // When ENTRIES == 2^LOG2, EntriesA is 0 and the subtraction is a no-op.
      addr_d = (load_val >= EntriesA) ? load_val - EntriesA : load_val;
    end else if (inc) begin
      addr_d = LOG2'(wrap_inc(32'(addr_q), ENTRIES));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/capture_dump_reader.sv
// Streams a completed capture from the circular RAM queue to the UART,
// oldest sample first.
//   clk, rst_n : clock, async active-low reset (aborts a dump, no done)
//   bus        : master side of capture_dump_reader_if
//                start/start_addr/dump_len : dump request, sampled in idle
//                raddr/rdata               : RAM read port
//                tx_data/trmt/tx_done      : UART transmit handshake
//                busy/done                 : dump status
module capture_dump_reader
  import capture_pkg::*;
#(
  parameter int unsigned ENTRIES = DefaultEntries,
  parameter int unsigned LOG2    = DefaultLog2,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  capture_dump_reader_if.master bus
);

  localparam int unsigned   LatW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LatW-1:0] LatLast  = LatW'(RD_LAT - 1);
  localparam logic [LOG2:0] EntriesLen = (LOG2 + 1)'(ENTRIES);

  state_e          state_q, state_d;
  logic [LOG2:0]   rem_q, rem_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            trmt_q, trmt_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic            addr_load;
  logic            addr_inc;
  logic [LOG2-1:0] raddr;
  logic [LOG2:0]   len_norm;

  assign len_norm = (bus.dump_len > EntriesLen) ? EntriesLen : bus.dump_len;

  circ_addr_ctr #(
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (addr_load),
    .load_val (bus.start_addr),
    .inc      (addr_inc),
    .addr     (raddr)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    lat_d     = lat_q;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    addr_load = 1'b0;
    addr_inc  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_load = 1'b1;
          rem_d     = len_norm;
          lat_d     = '0;
          busy_d    = 1'b1;
          state_d   = (len_norm == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LatLast) begin
          tx_data_d = bus.rdata;
          state_d   = StSend;
        end
      end
      StSend: begin
        addr_inc = 1'b1;
        rem_d    = rem_q - 1'b1;
        state_d  = StWaitTx;
      end
      StWaitTx: begin
        if (bus.tx_done) begin
          if (rem_q == '0) begin
            state_d = StDone;
          end else begin
            lat_d   = '0;
            state_d = StRead;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Pulse outputs are decoded from the next state so they are flop outputs
    // that coincide exactly with the SEND / DONE cycles.
    trmt_d = (state_d == StSend);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      lat_q     <= '0;
      tx_data_q <= '0;
      trmt_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      lat_q     <= lat_d;
      tx_data_q <= tx_data_d;
      trmt_q    <= trmt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.raddr   = raddr;
  assign bus.tx_data = tx_data_q;
  assign bus.trmt    = trmt_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule
